// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial add/subtract sequencer.
// Build option: SERIAL_ADDSUB_OVF_EN enables the signed-overflow flag.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_seq_cell.sv
// 1-bit full adder/subtractor cell; B is inverted when mode is set.
// Purely combinational, one instance per sequencer.
module addsub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic mode,
  output logic sum,
  output logic cout
);

  logic bx;
  logic p;

  assign bx   = b ^ mode;
  assign p    = a ^ bx;
  assign sum  = p ^ cin;
  assign cout = (a & bx) | (cin & p);

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer, LSB first, one bit per clock.
// Build option: SERIAL_ADDSUB_OVF_EN registers the signed-overflow flag.
module serial_addsub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);
  import serial_addsub_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             mode_q;
  logic             accept;
  logic             last;
  logic             bit_sum;
  logic             bit_cout;

  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  assign accept = start && !busy;
  assign last   = busy && (cnt == CNT_W'(WIDTH - 1));

  addsub_bit_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .mode (mode_q),
    .sum  (bit_sum),
    .cout (bit_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (last)  state_n = DONE;
      DONE:    state_n = start ? SHIFT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      mode_q <= MODE_ADD;
      result <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      cnt    <= '0;
      carry  <= mode;
      mode_q <= mode;
    end else if (busy) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      acc   <= {bit_sum, acc[WIDTH-1:1]};
      carry <= bit_cout;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        result <= {bit_sum, acc[WIDTH-1:1]};
        cout   <= bit_cout;
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  // carry still holds the carry into the MSB during the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    overflow <= 1'b0;
    else if (last) overflow <= carry ^ bit_cout;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
